// File: rtl/if_fetch_unit.sv
// Fetch stage feeding the instruction buffer: aligned 64-bit reads split into a two-lane packet pair.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
package if_fetch_unit_pkg;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
    } IF_IB_PACKET;
endpackage

module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned     MAX_OUTSTANDING = 4,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             ib_ready,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [63:0]      mem_rsp_data,
    output IF_IB_PACKET      if_ib_packet [0:1]
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_req_cnt,
    output logic [31:0]      perf_drop_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);
    localparam int unsigned     CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    // Repeated redirects while memory is slow can stack stale responses beyond MAX_OUTSTANDING.
    localparam int unsigned     DROP_W     = CNT_W + 4;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(7);

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [DROP_W-1:0] drop;
    logic              hold_valid;
    logic [63:0]       hold_data;
    logic [XLEN-1:0]   hold_pc;
    logic              out_valid;
    logic [63:0]       out_data;
    logic [XLEN-1:0]   out_pc;
    logic              running;

    logic [CNT_W:0]    in_use;
    logic              accept;
    logic              rsp_live;
    logic              rsp_drop;
    logic [DROP_W-1:0] pending;
    logic [DROP_W-1:0] drop_after_flush;

    always_comb begin
        in_use           = {1'b0, outstanding} + (CNT_W + 1)'(hold_valid);
        mem_req_valid    = running && !reset && !squash
                           && (in_use < (CNT_W + 1)'(MAX_OUTSTANDING));
        mem_req_addr     = fetch_pc;
        accept           = mem_req_valid && mem_req_ready;
        rsp_live         = mem_rsp_valid && (drop == '0);
        rsp_drop         = mem_rsp_valid && (drop != '0);
        // Everything in flight becomes stale; a response arriving now is the oldest of them.
        pending          = drop + DROP_W'(outstanding);
        drop_after_flush = pending - DROP_W'(mem_rsp_valid && (pending != '0));
    end

    always_ff @(posedge clock) begin
        running <= !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC & ALIGN_MASK;
            resp_pc     <= RESET_PC & ALIGN_MASK;
            outstanding <= '0;
            // A reset held past its first cycle is treated as power-on and forgets stale reads.
            drop        <= running ? drop_after_flush : '0;
            hold_valid  <= 1'b0;
            out_valid   <= 1'b0;
        end else if (squash) begin
            fetch_pc    <= branch_target & ALIGN_MASK;
            resp_pc     <= branch_target & ALIGN_MASK;
            outstanding <= '0;
            drop        <= drop_after_flush;
            hold_valid  <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (accept)   fetch_pc <= fetch_pc + XLEN'(8);
            if (rsp_live) resp_pc  <= resp_pc + XLEN'(8);
            if (rsp_drop) drop     <= drop - DROP_W'(1);
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_live);
            out_valid   <= 1'b0;

            if (hold_valid) begin
                if (ib_ready) begin
                    out_valid  <= 1'b1;
                    out_data   <= hold_data;
                    out_pc     <= hold_pc;
                    hold_valid <= rsp_live;
                    if (rsp_live) begin
                        hold_data <= mem_rsp_data;
                        hold_pc   <= resp_pc;
                    end
                end
            end else if (rsp_live) begin
                if (ib_ready) begin
                    out_valid <= 1'b1;
                    out_data  <= mem_rsp_data;
                    out_pc    <= resp_pc;
                end else begin
                    hold_valid <= 1'b1;
                    hold_data  <= mem_rsp_data;
                    hold_pc    <= resp_pc;
                end
            end
        end
    end

    always_comb begin
        if_ib_packet[0].valid = out_valid;
        if_ib_packet[0].inst  = out_data[31:0];
        if_ib_packet[0].pc    = out_pc;
        if_ib_packet[0].npc   = out_pc + XLEN'(4);
        if_ib_packet[1].valid = out_valid;
        if_ib_packet[1].inst  = out_data[63:32];
        if_ib_packet[1].pc    = out_pc + XLEN'(4);
        if_ib_packet[1].npc   = out_pc + XLEN'(8);
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_req_cnt   <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept)                             perf_req_cnt   <= perf_req_cnt + 32'd1;
            if (mem_rsp_valid && (squash || rsp_drop)) perf_drop_cnt <= perf_drop_cnt + 32'd1;
            if (hold_valid && !ib_ready)            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model, packet scoreboard, vector table and scripted corner cases.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [XLEN-1:0] RST_PC = '0;

    logic            clock = 1'b0;
    logic            reset, squash, ib_ready, mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [XLEN-1:0] branch_target, mem_req_addr;
    logic [63:0]     mem_rsp_data;
    IF_IB_PACKET     pkt [0:1];
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     perf_req_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

    if_fetch_unit #(.MAX_OUTSTANDING(4), .RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset), .squash(squash), .branch_target(branch_target),
        .ib_ready(ib_ready), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .if_ib_packet(pkt)
`ifdef FETCH_PERF_CNT_EN
        , .perf_req_cnt(perf_req_cnt), .perf_drop_cnt(perf_drop_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct { logic [XLEN-1:0] addr; int unsigned epoch; int unsigned cyc; } req_t;
    typedef struct { logic [XLEN-1:0] pc; logic [63:0] data; } exp_t;
    typedef struct {
        logic [XLEN-1:0] target; logic [63:0] data;
        logic [31:0] inst0, inst1; logic [XLEN-1:0] pc0, npc1;
    } vec_t;

    req_t            pend[$];
    exp_t            sb[$];
    int unsigned     epoch, cyc, checks, errors, pkt_count, accepts, mark;
    logic [XLEN-1:0] exp_pc, ovr_addr, mark_pc, mark_npc1;
    logic [31:0]     mark_inst0, mark_inst1, inst40_0, inst40_1;
    logic [XLEN-1:0] npc40_1;
    logic            seen40, rsp_en;
    logic [63:0]     ovr_data;

    task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_data(input logic [XLEN-1:0] a);
        if (a == ovr_addr)     return ovr_data;
        if (a == XLEN'('h40))  return 64'hDEADBEEF_00112233;
        return {a ^ 32'hA5A5_A5A5, a + 32'h1};
    endfunction

    // One clock: drive memory response, observe issue, clock, score the registered packet.
    task automatic tick();
        req_t r;
        exp_t e;
        if (reset || squash) begin
            epoch++;
            sb.delete();
            exp_pc = reset ? (RST_PC & ~XLEN'(7)) : (branch_target & ~XLEN'(7));
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (rsp_en && pend.size() != 0 && pend[0].cyc < cyc) begin
            r = pend.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_data(r.addr);
            if (r.epoch == epoch && !reset && !squash) sb.push_back('{r.addr, mem_rsp_data});
        end
        #1;
        if (reset || squash) check("req_blocked", mem_req_valid == 1'b0, 64'(mem_req_valid), 64'd0);
        if (mem_req_valid && mem_req_ready) begin
            check("req_addr", mem_req_addr == exp_pc, 64'(mem_req_addr), 64'(exp_pc));
            pend.push_back('{mem_req_addr, epoch, cyc});
            exp_pc += XLEN'(8);
            accepts++;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (pkt[0].valid || pkt[1].valid) begin
            pkt_count++;
            if (pkt_count == mark + 1) begin
                mark_pc = pkt[0].pc; mark_inst0 = pkt[0].inst;
                mark_inst1 = pkt[1].inst; mark_npc1 = pkt[1].npc;
            end
            if (pkt[0].pc == XLEN'('h40) && !seen40) begin
                seen40 = 1'b1; inst40_0 = pkt[0].inst; inst40_1 = pkt[1].inst; npc40_1 = pkt[1].npc;
            end
            if (sb.size() == 0) begin
                check("stray_pkt", 1'b0, 64'(pkt[0].pc), 64'd0);
            end else begin
                e = sb.pop_front();
                check("pkt", pkt[0].valid && pkt[1].valid
                      && pkt[0].inst == e.data[31:0] && pkt[1].inst == e.data[63:32]
                      && pkt[0].pc == e.pc && pkt[0].npc == e.pc + 32'd4
                      && pkt[1].pc == e.pc + 32'd4 && pkt[1].npc == e.pc + 32'd8,
                      {pkt[0].pc, pkt[0].inst}, {e.pc, e.data[31:0]});
            end
        end
        @(negedge clock);
    endtask

    task automatic check_idle(input string name);
        #1;
        check(name, mem_req_valid == 1'b0 && pkt[0].valid == 1'b0 && pkt[1].valid == 1'b0,
              {61'd0, mem_req_valid, pkt[0].valid, pkt[1].valid}, 64'd0);
    endtask

    task automatic drain();
        mem_req_ready = 1'b0; ib_ready = 1'b1; rsp_en = 1'b1;
        for (int i = 0; i < 12; i++) tick();
    endtask

    vec_t vecs [3];
    int unsigned a0, n0;

    initial begin
        vecs[0] = '{32'h0000_0200, 64'h1111_2222_3333_4444, 32'h3333_4444, 32'h1111_2222, 32'h0000_0200, 32'h0000_0208};
        vecs[1] = '{32'h0000_030C, 64'hCAFE_F00D_0BAD_BEEF, 32'h0BAD_BEEF, 32'hCAFE_F00D, 32'h0000_0308, 32'h0000_0310};
        vecs[2] = '{32'hFFFF_FFF9, 64'h0000_0001_8000_0000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFF8, 32'h0000_0000};

        checks = 0; errors = 0; epoch = 0; cyc = 0; pkt_count = 0; accepts = 0; mark = 0;
        ovr_addr = 32'h0000_0003; ovr_data = '0; seen40 = 1'b0;
        reset = 1'b1; squash = 1'b0; branch_target = '0; ib_ready = 1'b1;
        mem_req_ready = 1'b1; rsp_en = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

        // Power-on reset, then steady fetch from RESET_PC.
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        check_idle("first_cycle_after_reset");
        check("reset_addr", mem_req_addr == RST_PC, 64'(mem_req_addr), 64'(RST_PC));
        mark = pkt_count;
        for (int i = 0; i < 16; i++) tick();
        check("first_pair_pc", mark_pc == 32'h0 && pkt_count > mark, 64'(mark_pc), 64'h0);
        check("blk40", seen40 && inst40_0 == 32'h0011_2233 && inst40_1 == 32'hDEAD_BEEF
              && npc40_1 == 32'h48, {inst40_1, inst40_0}, 64'hDEADBEEF_00112233);

        // Outstanding limit with memory responses held off.
        drain();
        mem_req_ready = 1'b1; rsp_en = 1'b0; a0 = accepts;
        for (int i = 0; i < 8; i++) tick();
        check("max_outstanding", accepts - a0 == 4, 64'(accepts - a0), 64'd4);
        #1;
        check("req_stalled", mem_req_valid == 1'b0, 64'(mem_req_valid), 64'd0);
        rsp_en = 1'b1;
        for (int i = 0; i < 6 && accepts == a0 + 4; i++) tick();
        check("issue_resume", accepts > a0 + 4, 64'(accepts - a0), 64'd5);

        // Squash with three in flight: stale data discarded, fetch from aligned target.
        drain();
        mem_req_ready = 1'b1; rsp_en = 1'b0;
        for (int i = 0; i < 6 && pend.size() < 3; i++) tick();
        mem_req_ready = 1'b0;
        squash = 1'b1; branch_target = 32'h0000_0104;
        tick();
        squash = 1'b0;
        #1;
        check("squash_addr", mem_req_addr == 32'h100, 64'(mem_req_addr), 64'h100);
        mem_req_ready = 1'b1; rsp_en = 1'b1; mark = pkt_count;
        for (int i = 0; i < 12; i++) tick();
        check("squash_first_pc", pkt_count > mark && mark_pc == 32'h100, 64'(mark_pc), 64'h100);

        // Vector table: redirect, then decode of the first block fetched.
        foreach (vecs[k]) begin
            ovr_addr = vecs[k].target & ~XLEN'(7); ovr_data = vecs[k].data;
            squash = 1'b1; branch_target = vecs[k].target;
            tick();
            squash = 1'b0; mark = pkt_count;
            for (int i = 0; i < 12 && pkt_count == mark; i++) tick();
            check("vec_timeout", pkt_count > mark, 64'(pkt_count - mark), 64'd1);
            check("vec_lanes", mark_inst0 == vecs[k].inst0 && mark_inst1 == vecs[k].inst1
                  && mark_pc == vecs[k].pc0 && mark_npc1 == vecs[k].npc1,
                  {mark_inst1, mark_inst0}, {vecs[k].inst1, vecs[k].inst0});
        end

        // Back-pressure: one response held for two cycles, then drained before later responses.
        drain();
        mem_req_ready = 1'b1; rsp_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        mem_req_ready = 1'b0; ib_ready = 1'b0; rsp_en = 1'b1; n0 = pkt_count;
        tick();
        rsp_en = 1'b0;
        tick(); tick();
        check("held_no_output", pkt_count == n0, 64'(pkt_count - n0), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", perf_stall_cnt != 32'd0, 64'(perf_stall_cnt), 64'd2);
`endif
        ib_ready = 1'b1; rsp_en = 1'b1; mark = pkt_count;
        tick();
        check("hold_release", pkt_count == n0 + 1, 64'(pkt_count - n0), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        check("hold_then_rest", pkt_count == n0 + 4, 64'(pkt_count - n0), 64'd4);

        // Reset with two reads in flight.
        drain();
        mem_req_ready = 1'b1; rsp_en = 1'b0;
        for (int i = 0; i < 4 && pend.size() < 2; i++) tick();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("idle_after_midreset");
`ifdef FETCH_PERF_CNT_EN
        check("perf_reset", perf_req_cnt == 0 && perf_drop_cnt == 0 && perf_stall_cnt == 0,
              {perf_req_cnt, perf_drop_cnt}, 64'd0);
`endif
        a0 = accepts; mem_req_ready = 1'b1; rsp_en = 1'b1; mark = pkt_count;
        for (int i = 0; i < 12; i++) tick();
        check("restart_pc", pkt_count > mark && mark_pc == RST_PC, 64'(mark_pc), 64'(RST_PC));
`ifdef FETCH_PERF_CNT_EN
        check("perf_counts", perf_req_cnt == 32'(accepts - a0) && perf_drop_cnt == 32'd2,
              {perf_req_cnt, perf_drop_cnt}, {32'(accepts - a0), 32'd2});
`endif

        drain();
        check("scoreboard_empty", sb.size() == 0, 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
